regfile_exec_ctrl: RTL and testbench

- Single-issue execute/write-back sequencer that sits beside the 8x8-bit register file.
- Accepts one instruction at a time over a valid/ready handshake and drives the register file read-address ports.
- Captures both read operands, computes an 8-bit ALU result and drives the register file write port for one cycle.
- Fixed 4-cycle issue interval; no overlap between instructions.

---
 rtl/regfile_exec_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_regfile_exec_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_exec_ctrl.sv
// rtl/regfile_exec_ctrl.sv - single-issue execute/write-back sequencer for an 8x8 register file
//
// Purpose:
//   Accepts one instruction per 4-cycle slot over a valid/ready handshake,
//   reads two operands from the external register file, runs an 8-bit ALU
//   operation and drives the register file write port for one cycle.
//
// Ports:
//   clk_i, RES_ni                     clock, asynchronous active-low reset
//   instr_valid_i / instr_ready_o     instruction handshake
//   op_i, rd_i, rs1_i, rs2_i, imm_i   instruction fields
//   READ_ADDR1_o / READ_ADDR2_o       register file read addresses
//   RD_DATA1_i / RD_DATA2_i           register file read data (combinational)
//   WRT_EN_o, WRT_DEST_o, WRT_DATA_o  register file write port
//   done_o                            one-cycle pulse alongside WRT_EN_o
//   carry_o, zero_o                   flags of the last completed op
//
// Configuration:
//   EXEC_SAT_EN  when defined, ADD saturates to all-ones on carry and SUB
//                saturates to zero on borrow; carry_o still reports the raw flag.

module regfile_exec_ctrl #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          RES_ni,
    input  logic          instr_valid_i,
    output logic          instr_ready_o,
    input  logic [2:0]    op_i,
    input  logic [AW-1:0] rd_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    input  logic [DW-1:0] imm_i,
    output logic [AW-1:0] READ_ADDR1_o,
    output logic [AW-1:0] READ_ADDR2_o,
    input  logic [DW-1:0] RD_DATA1_i,
    input  logic [DW-1:0] RD_DATA2_i,
    output logic          WRT_EN_o,
    output logic [AW-1:0] WRT_DEST_o,
    output logic [DW-1:0] WRT_DATA_o,
    output logic          done_o,
    output logic          carry_o,
    output logic          zero_o
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t        r_state;
    logic [2:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic          r_ready;
    logic [AW-1:0] r_raddr1;
    logic [AW-1:0] r_raddr2;
    logic          r_wen;
    logic [AW-1:0] r_wdest;
    logic [DW-1:0] r_wdata;
    logic          r_done;
    logic          r_carry;
    logic          r_zero;

    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic [DW-1:0] w_result;
    logic          w_carry;
    logic          w_zero;

    // ALU works on the captured operands, so a write to rd never disturbs
    // the values used by the same instruction even when rd aliases rs1/rs2.
    always_comb begin
        w_sum    = {1'b0, r_a} + {1'b0, r_b};
        w_diff   = {1'b0, r_a} - {1'b0, r_b};
        w_result = '0;
        w_carry  = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_result = w_sum[DW-1:0];
                w_carry  = w_sum[DW];
            end
            OP_SUB: begin
                w_result = w_diff[DW-1:0];
                // Top bit of the widened difference is the borrow (A < B).
                w_carry  = w_diff[DW];
            end
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_SHL:  w_result = r_a << r_b[2:0];
            OP_SHR:  w_result = r_a >> r_b[2:0];
            OP_LDI:  w_result = r_imm;
            default: w_result = '0;
        endcase
`ifdef EXEC_SAT_EN
        if (r_op == OP_ADD && w_carry) begin
            w_result = '1;
        end
        if (r_op == OP_SUB && w_carry) begin
            w_result = '0;
        end
`endif
        w_zero = (w_result == '0);
    end

    always_ff @(posedge clk_i or negedge RES_ni) begin
        if (!RES_ni) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ready  <= 1'b1;
            r_raddr1 <= '0;
            r_raddr2 <= '0;
            r_wen    <= 1'b0;
            r_wdest  <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid_i) begin
                        r_op     <= op_i;
                        r_rd     <= rd_i;
                        r_imm    <= imm_i;
                        r_raddr1 <= rs1_i;
                        r_raddr2 <= rs2_i;
                        r_ready  <= 1'b0;
                        r_state  <= S_READ;
                    end
                end
                S_READ: begin
                    r_a     <= RD_DATA1_i;
                    r_b     <= RD_DATA2_i;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_wdata <= w_result;
                    r_wdest <= r_rd;
                    r_carry <= w_carry;
                    r_zero  <= w_zero;
                    r_wen   <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_wen   <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_wen   <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready_o = r_ready;
    assign READ_ADDR1_o  = r_raddr1;
    assign READ_ADDR2_o  = r_raddr2;
    assign WRT_EN_o      = r_wen;
    assign WRT_DEST_o    = r_wdest;
    assign WRT_DATA_o    = r_wdata;
    assign done_o        = r_done;
    assign carry_o       = r_carry;
    assign zero_o        = r_zero;

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// tb/tb_regfile_exec_ctrl.sv - directed self-checking bench for regfile_exec_ctrl

module tb_regfile_exec_ctrl;

    logic       clk;
    logic       RES_ni;
    logic       instr_valid_i;
    logic       instr_ready_o;
    logic [2:0] op_i;
    logic [2:0] rd_i;
    logic [2:0] rs1_i;
    logic [2:0] rs2_i;
    logic [7:0] imm_i;
    logic [2:0] READ_ADDR1_o;
    logic [2:0] READ_ADDR2_o;
    logic [7:0] RD_DATA1_i;
    logic [7:0] RD_DATA2_i;
    logic       WRT_EN_o;
    logic [2:0] WRT_DEST_o;
    logic [7:0] WRT_DATA_o;
    logic       done_o;
    logic       carry_o;
    logic       zero_o;

    logic [7:0] rf [8];
    logic       pl_en;
    logic [2:0] pl_addr;
    logic [7:0] pl_data;

    int checks;
    int failures;

    regfile_exec_ctrl #(.DW(8), .AW(3)) dut (
        .clk_i        (clk),
        .RES_ni       (RES_ni),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .op_i         (op_i),
        .rd_i         (rd_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .imm_i        (imm_i),
        .READ_ADDR1_o (READ_ADDR1_o),
        .READ_ADDR2_o (READ_ADDR2_o),
        .RD_DATA1_i   (RD_DATA1_i),
        .RD_DATA2_i   (RD_DATA2_i),
        .WRT_EN_o     (WRT_EN_o),
        .WRT_DEST_o   (WRT_DEST_o),
        .WRT_DATA_o   (WRT_DATA_o),
        .done_o       (done_o),
        .carry_o      (carry_o),
        .zero_o       (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, write on rising edge.
    assign RD_DATA1_i = rf[READ_ADDR1_o];
    assign RD_DATA2_i = rf[READ_ADDR2_o];
    always @(posedge clk) begin
        if (WRT_EN_o) rf[WRT_DEST_o] <= WRT_DATA_o;
        if (pl_en) rf[pl_addr] <= pl_data;
    end

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one instruction and observes the following 6 cycles.
    task automatic exec_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [7:0] imm,
                           output int wcnt, output int dcnt, output logic [7:0] data,
                           output logic [2:0] dest, output logic c, output logic z);
        int waitc;
        wcnt = 0; dcnt = 0; data = 8'h00; dest = 3'd0; c = 1'b0; z = 1'b0;
        waitc = 0;
        @(negedge clk);
        while (!instr_ready_o && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (!instr_ready_o) return;
        instr_valid_i = 1'b1; op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr_valid_i = 1'b0;
            if (done_o) dcnt++;
            if (WRT_EN_o) begin
                wcnt++;
                data = WRT_DATA_o; dest = WRT_DEST_o; c = carry_o; z = zero_o;
            end
        end
    endtask

    task automatic test_reset;
        RES_ni = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (WRT_EN_o !== 1'b0 || done_o !== 1'b0 || carry_o !== 1'b0 || zero_o !== 1'b0 || WRT_DATA_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: wen=%b done=%b c=%b z=%b wdata=%h required all 0", WRT_EN_o, done_o, carry_o, zero_o, WRT_DATA_o);
        end
        RES_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b required 1", instr_ready_o);
        end
    endtask

    task automatic test_ldi;
        int w, d; logic [7:0] data; logic [2:0] dest; logic c, z;
        exec_op(3'd7, 3'd3, 3'd0, 3'd0, 8'h5A, w, d, data, dest, c, z);
        checks++;
        if (w !== 1 || d !== 1) begin
            failures++;
            $display("FAIL ldi_pulses: wen=%0d done=%0d required 1 1", w, d);
        end
        checks++;
        if (data !== 8'h5A || dest !== 3'd3 || z !== 1'b0 || c !== 1'b0) begin
            failures++;
            $display("FAIL ldi_result: data=%h dest=%0d c=%b z=%b required 5a 3 0 0", data, dest, c, z);
        end
        checks++;
        if (rf[3] !== 8'h5A) begin
            failures++;
            $display("FAIL ldi_reg3: got %h required 5a", rf[3]);
        end
    endtask

    task automatic test_add;
        int w, d; logic [7:0] data; logic [2:0] dest; logic c, z; logic [7:0] exp_d;
`ifdef EXEC_SAT_EN
        exp_d = 8'hFF;
`else
        exp_d = 8'h10;
`endif
        preload(3'd1, 8'hF0);
        preload(3'd2, 8'h20);
        exec_op(3'd0, 3'd4, 3'd1, 3'd2, 8'h00, w, d, data, dest, c, z);
        checks++;
        if (w !== 1 || data !== exp_d || c !== 1'b1 || z !== 1'b0 || rf[4] !== exp_d) begin
            failures++;
            $display("FAIL add_carry: w=%0d data=%h c=%b z=%b reg4=%h required 1 %h 1 0 %h", w, data, c, z, rf[4], exp_d, exp_d);
        end
    endtask

    task automatic test_sub;
        int w, d; logic [7:0] data; logic [2:0] dest; logic c, z; logic [7:0] exp_d; logic exp_z;
        preload(3'd1, 8'h33);
        preload(3'd2, 8'h33);
        exec_op(3'd1, 3'd5, 3'd1, 3'd2, 8'h00, w, d, data, dest, c, z);
        checks++;
        if (w !== 1 || data !== 8'h00 || z !== 1'b1 || c !== 1'b0 || rf[5] !== 8'h00) begin
            failures++;
            $display("FAIL sub_zero: w=%0d data=%h c=%b z=%b reg5=%h required 1 00 0 1 00", w, data, c, z, rf[5]);
        end
`ifdef EXEC_SAT_EN
        exp_d = 8'h00; exp_z = 1'b1;
`else
        exp_d = 8'hFF; exp_z = 1'b0;
`endif
        preload(3'd1, 8'h01);
        preload(3'd2, 8'h02);
        exec_op(3'd1, 3'd5, 3'd1, 3'd2, 8'h00, w, d, data, dest, c, z);
        checks++;
        if (w !== 1 || data !== exp_d || c !== 1'b1 || z !== exp_z) begin
            failures++;
            $display("FAIL sub_borrow: w=%0d data=%h c=%b z=%b required 1 %h 1 %b", w, data, c, z, exp_d, exp_z);
        end
    endtask

    task automatic test_shift_logic;
        int w, d; logic [7:0] data; logic [2:0] dest; logic c, z;
        preload(3'd6, 8'h81);
        preload(3'd7, 8'h03);
        exec_op(3'd5, 3'd6, 3'd6, 3'd7, 8'h00, w, d, data, dest, c, z);
        checks++;
        if (w !== 1 || rf[6] !== 8'h08 || c !== 1'b0 || z !== 1'b0) begin
            failures++;
            $display("FAIL shl_alias: w=%0d reg6=%h c=%b z=%b required 1 08 0 0", w, rf[6], c, z);
        end
        preload(3'd6, 8'h81);
        exec_op(3'd6, 3'd1, 3'd6, 3'd7, 8'h00, w, d, data, dest, c, z);
        checks++;
        if (w !== 1 || rf[1] !== 8'h10 || dest !== 3'd1) begin
            failures++;
            $display("FAIL shr: w=%0d reg1=%h dest=%0d required 1 10 1", w, rf[1], dest);
        end
        preload(3'd2, 8'hFF);
        preload(3'd3, 8'h0F);
        exec_op(3'd4, 3'd0, 3'd2, 3'd3, 8'h00, w, d, data, dest, c, z);
        checks++;
        if (w !== 1 || rf[0] !== 8'hF0 || c !== 1'b0) begin
            failures++;
            $display("FAIL xor: w=%0d reg0=%h c=%b required 1 f0 0", w, rf[0], c);
        end
        exec_op(3'd2, 3'd4, 3'd2, 3'd3, 8'h00, w, d, data, dest, c, z);
        checks++;
        if (w !== 1 || rf[4] !== 8'h0F) begin
            failures++;
            $display("FAIL and: w=%0d reg4=%h required 1 0f", w, rf[4]);
        end
    endtask

    task automatic test_idle_hold;
        logic [7:0] wd; logic [2:0] a1;
        @(negedge clk);
        wd = WRT_DATA_o; a1 = READ_ADDR1_o;
        op_i = 3'd7; rd_i = 3'd2; rs1_i = 3'd5; imm_i = 8'hEE;
        repeat (3) @(negedge clk);
        checks++;
        if (instr_ready_o !== 1'b1 || WRT_EN_o !== 1'b0 || WRT_DATA_o !== wd || READ_ADDR1_o !== a1) begin
            failures++;
            $display("FAIL idle_hold: rdy=%b wen=%b wdata=%h a1=%0d required 1 0 %h %0d", instr_ready_o, WRT_EN_o, WRT_DATA_o, READ_ADDR1_o, wd, a1);
        end
    endtask

    task automatic test_back_to_back;
        int idx, cyc, wcnt, low_cnt;
        int acc [3];
        idx = 0; cyc = 0; wcnt = 0; low_cnt = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (WRT_EN_o) wcnt++;
            if (instr_ready_o && idx < 3) begin
                instr_valid_i = 1'b1;
                case (idx)
                    0: begin op_i = 3'd7; rd_i = 3'd0; rs1_i = 3'd0; rs2_i = 3'd0; imm_i = 8'h11; end
                    1: begin op_i = 3'd7; rd_i = 3'd1; rs1_i = 3'd0; rs2_i = 3'd0; imm_i = 8'h22; end
                    default: begin op_i = 3'd0; rd_i = 3'd2; rs1_i = 3'd0; rs2_i = 3'd1; imm_i = 8'h00; end
                endcase
                acc[idx] = cyc;
                idx++;
            end else if (instr_ready_o) begin
                instr_valid_i = 1'b0;
            end else if (idx > 0 && idx < 3) begin
                low_cnt++;
            end
        end
        instr_valid_i = 1'b0;
        checks++;
        if (idx !== 3) begin
            failures++;
            $display("FAIL b2b_accepts: got %0d required 3", idx);
        end else begin
            checks++;
            if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d %0d required 4 4", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        checks++;
        if (low_cnt !== 6) begin
            failures++;
            $display("FAIL b2b_ready_low: got %0d required 6", low_cnt);
        end
        checks++;
        if (wcnt !== 3 || rf[2] !== 8'h33) begin
            failures++;
            $display("FAIL b2b_writes: wen=%0d reg2=%h required 3 33", wcnt, rf[2]);
        end
    endtask

    task automatic test_reset_mid;
        int wcnt;
        wcnt = 0;
        preload(3'd1, 8'h01);
        preload(3'd2, 8'h02);
        preload(3'd5, 8'hA5);
        @(negedge clk);
        instr_valid_i = 1'b1; op_i = 3'd0; rd_i = 3'd5; rs1_i = 3'd1; rs2_i = 3'd2; imm_i = 8'h00;
        @(posedge clk);
        @(negedge clk);
        instr_valid_i = 1'b0;
        @(negedge clk);
        RES_ni = 1'b0;
        #1;
        checks++;
        if (WRT_EN_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: wen=%b done=%b required 0 0", WRT_EN_o, done_o);
        end
        @(negedge clk);
        RES_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (WRT_EN_o) wcnt++;
        end
        checks++;
        if (wcnt !== 0 || rf[5] !== 8'hA5 || instr_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state: wen=%0d reg5=%h rdy=%b required 0 a5 1", wcnt, rf[5], instr_ready_o);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        RES_ni = 1'b0; instr_valid_i = 1'b0;
        op_i = 3'd0; rd_i = 3'd0; rs1_i = 3'd0; rs2_i = 3'd0; imm_i = 8'h00;
        pl_en = 1'b0; pl_addr = 3'd0; pl_data = 8'h00;
        for (int i = 0; i < 8; i++) preload(i[2:0], 8'h00);
        test_reset();
        test_ldi();
        test_add();
        test_sub();
        test_shift_logic();
        test_idle_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
